// File: rtl/ram_arb_pkg.sv
// Purpose: shared types and constants for the RAM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

    // Which requester currently drives the RAM port.
    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } owner_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int DMA_BURST_DEF    = 8;

    // Both counters share one width: enough bits to hold the larger limit.
    function automatic int arb_cnt_w(input int starve_limit, input int dma_burst);
        int m;
        m = (starve_limit > dma_burst) ? starve_limit : dma_burst;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Purpose: bundle of CPU MEM-stage, DMA and RAM-side signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: DMA is held off through dma_gnt, the CPU through cpu_stall.
// Ports (slave = arbiter view):
//   cpu_req/we/addr/wdata in, cpu_rdata/cpu_stall out
//   dma_req/we/addr/wdata in, dma_rdata/dma_gnt out
//   ram_addr/wdata/MemRead/MemWrite out, ram_out in (combinational RAM read)
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_gnt;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_MemRead;
    logic              ram_MemWrite;
    logic [DATA_W-1:0] ram_out;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_gnt,
        output ram_addr, ram_wdata, ram_MemRead, ram_MemWrite,
        input  ram_out
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_gnt,
        input  ram_addr, ram_wdata, ram_MemRead, ram_MemWrite,
        output ram_out
    );

endinterface

// File: rtl/arb_limit_counter.sv
// Purpose: clear/increment counter flagging terminal count (cnt == LIMIT-1).
// Latency: tc_o reflects the registered count; clr/inc take effect next edge.
// Backpressure: none; clear has priority over increment, otherwise holds.
// Ports: clk, rst_n (async active-low), clr_i, inc_i in; tc_o out.
module arb_limit_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/ram_port_arbiter.sv
// Purpose: shares one RAM port between the CPU MEM stage and a DMA master.
// Latency: port mux and read data are combinational; ownership changes take 1 cycle.
// Backpressure: CPU frozen via cpu_stall while DMA owns; DMA waits on dma_gnt.
// Ports: clk, reset (async active-low), bus (ram_port_arbiter_if.slave).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int DMA_BURST    = DMA_BURST_DEF
) (
    input  logic                clk,
    input  logic                reset,
    ram_port_arbiter_if.slave   bus
);

    localparam int CNT_W = arb_cnt_w(STARVE_LIMIT, DMA_BURST);

    owner_t owner_q;
    owner_t owner_d;

    logic starve_clr;
    logic starve_inc;
    logic starve_tc;
    logic burst_clr;
    logic burst_inc;
    logic burst_tc;

    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;
    logic              mux_rd;
    logic              mux_wr;

    // Counts contended cycles the CPU has kept the port while DMA waits.
    arb_limit_counter #(
        .W     (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (starve_clr),
        .inc_i (starve_inc),
        .tc_o  (starve_tc)
    );

    // Counts contended cycles DMA has held the port while the CPU waits.
    arb_limit_counter #(
        .W     (CNT_W),
        .LIMIT (DMA_BURST)
    ) u_burst (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (burst_clr),
        .inc_i (burst_inc),
        .tc_o  (burst_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= S_CPU;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Ownership arbitration. The access of the current owner always completes
    // in the cycle a switch is decided; the new owner gets the port next cycle.
    always_comb begin
        owner_d    = owner_q;
        starve_clr = 1'b0;
        starve_inc = 1'b0;
        burst_clr  = 1'b0;
        burst_inc  = 1'b0;
        if (owner_q == S_CPU) begin
            if (bus.dma_req && (!bus.cpu_req || starve_tc)) begin
                owner_d    = S_DMA;
                starve_clr = 1'b1;
            end else if (bus.cpu_req && bus.dma_req) begin
                starve_inc = 1'b1;
            end else begin
                starve_clr = 1'b1;
            end
        end else begin
            if (!bus.dma_req) begin
                owner_d   = S_CPU;
                burst_clr = 1'b1;
            end else if (bus.cpu_req && burst_tc) begin
                owner_d   = S_CPU;
                burst_clr = 1'b1;
            end else if (bus.cpu_req) begin
                burst_inc = 1'b1;
            end
            // Uncontended DMA keeps the port without consuming its burst budget.
        end
    end

    // Port mux. Writes are suppressed while reset is low so a transfer caught
    // by reset mid-cycle never reaches the RAM; reads are harmless.
    always_comb begin
        mux_addr  = bus.cpu_addr;
        mux_wdata = bus.cpu_wdata;
        mux_rd    = bus.cpu_req & ~bus.cpu_we;
        mux_wr    = bus.cpu_req & bus.cpu_we;
        if (owner_q == S_DMA) begin
            mux_addr  = bus.dma_addr;
            mux_wdata = bus.dma_wdata;
            mux_rd    = bus.dma_req & ~bus.dma_we;
            mux_wr    = bus.dma_req & bus.dma_we;
        end
    end

    assign bus.ram_addr     = mux_addr;
    assign bus.ram_wdata    = mux_wdata;
    assign bus.ram_MemRead  = mux_rd;
    assign bus.ram_MemWrite = mux_wr & reset;

    assign bus.cpu_rdata = bus.ram_out;
    assign bus.dma_rdata = bus.ram_out;
    assign bus.dma_gnt   = (owner_q == S_DMA);
    assign bus.cpu_stall = (owner_q == S_DMA) & bus.cpu_req;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose: bench for ram_port_arbiter; default limits and STARVE_LIMIT=DMA_BURST=1 side by side.
// Latency: outputs sampled mid-cycle, RAM writes applied at the rising edge.
// Backpressure: the DMA master holds each request until it sees dma_gnt.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

    ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4), .DMA_BURST(8)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(1), .DMA_BURST(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Environment RAMs, one per arbiter, with combinational read.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    assign bus0.cpu_req = cpu_req;   assign bus1.cpu_req = cpu_req;
    assign bus0.cpu_we = cpu_we;     assign bus1.cpu_we = cpu_we;
    assign bus0.cpu_addr = cpu_addr; assign bus1.cpu_addr = cpu_addr;
    assign bus0.cpu_wdata = cpu_wdata; assign bus1.cpu_wdata = cpu_wdata;
    assign bus0.dma_req = dma_req;   assign bus1.dma_req = dma_req;
    assign bus0.dma_we = dma_we;     assign bus1.dma_we = dma_we;
    assign bus0.dma_addr = dma_addr; assign bus1.dma_addr = dma_addr;
    assign bus0.dma_wdata = dma_wdata; assign bus1.dma_wdata = dma_wdata;
    assign bus0.ram_out = mem0[bus0.ram_addr];
    assign bus1.ram_out = mem1[bus1.ram_addr];

    int n_chk = 0;
    int n_err = 0;

    // Reference model: who owns the port, how many contended cycles the CPU
    // has served while DMA waited, and how many contended cycles DMA has served.
    logic       m_own [2];
    int         m_cpu_run [2];
    int         m_dma_run [2];
    logic [7:0] ref_mem [2][256];
    logic       e_wr [2];
    logic [7:0] e_addr [2];
    logic [7:0] e_wdata [2];

    // Observations captured in the last cycle().
    logic       s_gnt0, s_wr0, s_stall0, s_stall1, s_wr1;
    logic [7:0] s_drd0, s_addr0, s_wd0, s_addr1, s_wd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_side(input int k, input logic gnt, input logic stall,
                              input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] crd,
                              input logic [7:0] drd);
        logic own;
        logic er;
        own = reset ? m_own[k] : 1'b0;
        if (own) begin
            e_addr[k]  = dma_addr;
            e_wdata[k] = dma_wdata;
            er         = dma_req & ~dma_we;
            e_wr[k]    = dma_req & dma_we;
        end else begin
            e_addr[k]  = cpu_addr;
            e_wdata[k] = cpu_wdata;
            er         = cpu_req & ~cpu_we;
            e_wr[k]    = cpu_req & cpu_we;
        end
        if (!reset) e_wr[k] = 1'b0;
        chk($sformatf("gnt%0d", k),   32'(gnt),   32'(own));
        chk($sformatf("stall%0d", k), 32'(stall), 32'(own & cpu_req));
        chk($sformatf("rd%0d", k),    32'(rd),    32'(er));
        chk($sformatf("wr%0d", k),    32'(wr),    32'(e_wr[k]));
        chk($sformatf("addr%0d", k),  32'(addr),  32'(e_addr[k]));
        chk($sformatf("wdata%0d", k), 32'(wdata), 32'(e_wdata[k]));
        chk($sformatf("cpu_rdata%0d", k), 32'(crd), 32'(ref_mem[k][e_addr[k]]));
        chk($sformatf("dma_rdata%0d", k), 32'(drd), 32'(ref_mem[k][e_addr[k]]));
    endtask

    task automatic model_step(input int k, input int starve_limit, input int dma_burst);
        if (e_wr[k]) ref_mem[k][e_addr[k]] = e_wdata[k];
        if (!reset) begin
            m_own[k] = 1'b0; m_cpu_run[k] = 0; m_dma_run[k] = 0;
        end else if (!m_own[k]) begin
            if (dma_req && (!cpu_req || m_cpu_run[k] + 1 >= starve_limit)) begin
                m_own[k] = 1'b1; m_cpu_run[k] = 0;
            end else if (cpu_req && dma_req) begin
                m_cpu_run[k] = m_cpu_run[k] + 1;
            end else begin
                m_cpu_run[k] = 0;
            end
        end else begin
            if (!dma_req) begin
                m_own[k] = 1'b0; m_dma_run[k] = 0;
            end else if (cpu_req) begin
                m_dma_run[k] = m_dma_run[k] + 1;
                if (m_dma_run[k] >= dma_burst) begin
                    m_own[k] = 1'b0; m_dma_run[k] = 0;
                end
            end
        end
    endtask

    // Called 1 time unit after a rising edge with inputs already set.
    task automatic cycle();
        #3;
        s_gnt0 = bus0.dma_gnt; s_wr0 = bus0.ram_MemWrite; s_stall0 = bus0.cpu_stall;
        s_stall1 = bus1.cpu_stall; s_drd0 = bus0.dma_rdata; s_wr1 = bus1.ram_MemWrite;
        s_addr0 = bus0.ram_addr; s_wd0 = bus0.ram_wdata;
        s_addr1 = bus1.ram_addr; s_wd1 = bus1.ram_wdata;
        check_side(0, bus0.dma_gnt, bus0.cpu_stall, bus0.ram_MemRead, bus0.ram_MemWrite,
                   bus0.ram_addr, bus0.ram_wdata, bus0.cpu_rdata, bus0.dma_rdata);
        check_side(1, bus1.dma_gnt, bus1.cpu_stall, bus1.ram_MemRead, bus1.ram_MemWrite,
                   bus1.ram_addr, bus1.ram_wdata, bus1.cpu_rdata, bus1.dma_rdata);
        @(posedge clk);
        if (s_wr0) mem0[s_addr0] = s_wd0;
        if (s_wr1) mem1[s_addr1] = s_wd1;
        model_step(0, 4, 8);
        model_step(1, 1, 1);
        #1;
    endtask

    initial begin
        int idx;
        int n;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'(i * 7 + 3);
            mem1[i] = 8'(i * 7 + 3);
            ref_mem[0][i] = 8'(i * 7 + 3);
            ref_mem[1][i] = 8'(i * 7 + 3);
        end
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 1'b0; m_cpu_run[k] = 0; m_dma_run[k] = 0;
            e_wr[k] = 1'b0; e_addr[k] = '0; e_wdata[k] = '0;
        end

        // Reset held low with a CPU store pending: no write may escape.
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
        cycle();
        chk("reset_memwrite", 32'(s_wr0), 32'd0);
        chk("reset_gnt", 32'(s_gnt0), 32'd0);
        chk("reset_stall", 32'(s_stall0), 32'd0);
        reset = 1'b1;
        cycle();
        chk("cpu_store_10", 32'(mem0[8'h10]), 32'hA5);

        // Uncontended DMA burst of three writes.
        cpu_req = 1'b0; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1;
        idx = 0; n = 0;
        while (idx < 3 && n < 20) begin
            dma_addr = 8'(8'h20 + idx); dma_wdata = 8'(idx + 1);
            cycle();
            if (n == 0) chk("dma_first_gnt", 32'(s_gnt0), 32'd0);
            n++;
            if (s_gnt0) idx++;
        end
        chk("dma_burst_cycles", n, 4);
        dma_req = 1'b0;
        cycle();
        chk("dma_drop_gnt", 32'(s_gnt0), 32'd1);
        cycle();
        chk("dma_back_cpu", 32'(s_gnt0), 32'd0);
        chk("dma_wr_20", 32'(mem0[8'h20]), 32'h01);
        chk("dma_wr_21", 32'(mem0[8'h21]), 32'h02);
        chk("dma_wr_22", 32'(mem0[8'h22]), 32'h03);

        // Full contention: CPU store vs DMA read of 0x10.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h5A;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h10;
        for (int i = 0; i < 24; i++) begin
            cycle();
            chk($sformatf("pattern_stall0_%0d", i), 32'(s_stall0), 32'((i % 12) >= 4));
            chk($sformatf("pattern_stall1_%0d", i), 32'(s_stall1), 32'(i % 2));
            if (s_gnt0) chk("dma_read_10", 32'(s_drd0), 32'hA5);
        end
        chk("cpu_store_30", 32'(mem0[8'h30]), 32'h5A);

        // Reset pulsed during the third DMA write.
        cpu_req = 1'b0; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_wdata = 8'h11;
        cycle();
        cycle();
        dma_addr = 8'h41; dma_wdata = 8'h22;
        cycle();
        dma_addr = 8'h42; dma_wdata = 8'h33;
        #1 reset = 1'b0;
        cycle();
        chk("rst_mid_wr", 32'(s_wr0), 32'd0);
        chk("rst_mid_gnt", 32'(s_gnt0), 32'd0);
        dma_req = 1'b0;
        reset = 1'b1;
        chk("rst_wr_40", 32'(mem0[8'h40]), 32'h11);
        chk("rst_wr_41", 32'(mem0[8'h41]), 32'h22);
        chk("rst_dropped_42", 32'(mem0[8'h42]), 32'hD1);

        // After reset the counters must start from zero: full 4-cycle CPU window.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h22;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk($sformatf("post_rst_stall0_%0d", i), 32'(s_stall0), 32'(i >= 4));
            chk($sformatf("post_rst_stall1_%0d", i), 32'(s_stall1), 32'(i % 2));
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            if (!dma_req || s_gnt0) begin
                if ($urandom_range(0, 2) != 0) begin
                    dma_req = 1'b1;
                    dma_we = 1'($urandom);
                    dma_addr = 8'($urandom_range(0, 15));
                    dma_wdata = 8'($urandom);
                end else begin
                    dma_req = 1'b0;
                end
            end
            cpu_req = ($urandom_range(0, 3) != 0);
            cpu_we = 1'($urandom);
            cpu_addr = 8'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
            cycle();
        end

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final_mem0_%0d", i), 32'(mem0[i]), 32'(ref_mem[0][i]));
            chk($sformatf("final_mem1_%0d", i), 32'(mem1[i]), 32'(ref_mem[1][i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single ram_256B data port between two requesters: the CPU MEM stage and an external DMA/program-loader master.
- Sits between the EX/MEM pipeline register outputs and the RAM.
- CPU has default ownership. DMA is granted the port in bounded bursts.
- Starvation of either side is prevented by counters. `cpu_stall` freezes the pipeline whenever the MEM stage needs the port but does not own it.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- STARVE_LIMIT, 4, max consecutive contended CPU cycles before DMA is forced in (≥1).
- DMA_BURST, 8, max consecutive DMA grant cycles while CPU is waiting (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM stage access request (MEM_MemRead | MEM_MemWrite).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  MEM_aluout.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  read data to MEM/WB.
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB.
- dma_req  in  1  DMA access request, held until granted.
- dma_we  in  1  DMA write enable.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  DMA read data.
- dma_gnt  out  1  DMA owns port this cycle; transfer completes when dma_req && dma_gnt.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_wdata  out  DATA_W  to RAM wdata.
- ram_MemRead  out  1  to RAM MemRead.
- ram_MemWrite  out  1  to RAM MemWrite.
- ram_out  in  DATA_W  RAM read data (combinational read).

Behaviour:
- State register `owner` ∈ {S_CPU, S_DMA}; counters `starve_cnt` and `burst_cnt`, each $clog2(max(STARVE_LIMIT, DMA_BURST)+1) bits.
- Reset (reset=0, async), values hold while low:
  - owner = S_CPU, both counters = 0.
  - Therefore dma_gnt = 0 and cpu_stall = 0.
  - ram_MemRead = cpu_req & ~cpu_we; ram_MemWrite is forced to 0 while reset is low.
- Port mux (combinational from owner):
  - S_CPU: ram_* driven from cpu_*; ram_MemRead = cpu_req & ~cpu_we; ram_MemWrite = cpu_req & cpu_we.
  - S_DMA: ram_* driven from dma_*; ram_MemRead = dma_req & ~dma_we; ram_MemWrite = dma_req & dma_we.
- cpu_rdata = ram_out and dma_rdata = ram_out at all times. Each is meaningful only when that side owns the port; read data is valid in the same cycle as the request.
- dma_gnt = (owner == S_DMA).
- cpu_stall = (owner == S_DMA) & cpu_req.
- S_CPU transitions:
  - If dma_req and either !cpu_req or starve_cnt == STARVE_LIMIT-1: next owner = S_DMA, starve_cnt = 0.
  - Else if cpu_req & dma_req: starve_cnt += 1.
  - Else: starve_cnt = 0.
  - The CPU access in the switching cycle still completes; the switch costs exactly 1 cycle of DMA latency.
- S_DMA transitions:
  - If !dma_req: next owner = S_CPU, burst_cnt = 0.
  - Else if cpu_req and burst_cnt == DMA_BURST-1: next owner = S_CPU, burst_cnt = 0.
  - Else if cpu_req: burst_cnt += 1.
  - Else: burst_cnt holds (uncontended DMA runs unbounded, no count).
- Worst-case CPU stall is DMA_BURST cycles per arbitration round.
- Worst-case DMA wait is STARVE_LIMIT cycles after dma_req rises.
- Simultaneous requests in S_CPU with starve_cnt < STARVE_LIMIT-1: CPU wins.
- Reset asserted mid-burst: the DMA transfer in that cycle is dropped (MemWrite forced 0); owner returns to S_CPU.
- Parameter = 1 edge case:
  - STARVE_LIMIT=1: DMA wins after one contended cycle.
  - DMA_BURST=1: strict alternation under full contention.

Decomposition:
- Package ram_arb_pkg holds:
  - owner_t enum {S_CPU=1'b0, S_DMA=1'b1}
  - default constants for STARVE_LIMIT and DMA_BURST
  - a function computing the counter width.
- One sub-module is natural: arb_limit_counter. It is a clear/increment counter with a terminal-count flag (cnt == LIMIT-1), instantiated twice, for starve and burst.

Test Plan:
- Reset low with cpu_req=1, cpu_we=1 -> ram_MemWrite=0, dma_gnt=0, cpu_stall=0. Release reset, cpu_we=1, addr 0x10, data 0xA5 -> RAM[0x10]=0xA5 next edge.
- CPU idle, dma_req=1 for 3 writes (0x20..0x22 = 1,2,3) -> dma_gnt rises 1 cycle after dma_req; the 3 writes land on consecutive edges; owner returns to S_CPU 1 cycle after dma_req drops.
- cpu_req and dma_req both held high, defaults -> 4 CPU cycles (cpu_stall=0), then 8 DMA cycles with cpu_stall=1, then the pattern repeats.
- DMA read of 0x10 while CPU stalled -> dma_rdata=0xA5 in the grant cycle. The CPU's pending store is unchanged and executes on return to S_CPU.
- Reset pulsed low during DMA write burst cycle 3 -> that write is not performed; owner=S_CPU; counters 0 immediately (async).
- STARVE_LIMIT=1, DMA_BURST=1, both requesting -> owner alternates every cycle and cpu_stall toggles 0,1,0,1.
